// File: rtl/pc_sequencer_pkg.sv
// Shared types for the program-counter sequencer: FSM states and next-PC source select.
package pc_seq_pkg;

    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_TGT,
        SEL_POP
    } sel_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: pointer-based LIFO; push when full and pop when empty do nothing.
module return_addr_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  count;
    logic [IDX_W-1:0]  top_idx;
    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic              do_pop;
    logic              do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign top     = mem[top_idx];

    // Pop wins if both are requested; the sequencer never asks for both at once.
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (do_pop) begin
            count <= count - CNT_W'(1);
        end else if (do_push) begin
            count <= count + CNT_W'(1);
        end
    end

    // Entries need no reset: the count alone defines which ones are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[count[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boot cycle, then sequential/branch/jump/call/ret fetch addressing
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] WRAP_PC   = ADDR_W'(7),
    parameter logic [ADDR_W-1:0] INCR      = ADDR_W'(1),
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
        return (pc == WRAP_PC) ? RESET_PC : pc + INCR;
    endfunction

    state_t            state;
    state_t            state_next;
    sel_t              sel;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_push;
    logic              ras_pop;
    logic              set_ovf;
    logic              set_unf;
    logic              advance;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:  state_next = S_RUN;
            S_RUN:   state_next = S_RUN;
            default: state_next = S_BOOT;
        endcase
    end

    always_comb begin
        addr_valid = 1'b0;
        if (state == S_RUN) begin
            addr_valid = 1'b1;
        end
    end

    assign advance = addr_valid && !stall;

    // Priority ret > call > jump > branch > sequential; losers are dropped, not queued.
    always_comb begin
        sel      = SEL_SEQ;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        if (advance) begin
            if (ret) begin
                if (!ras_empty) begin
                    sel     = SEL_POP;
                    ras_pop = 1'b1;
                end else begin
                    set_unf = 1'b1;
                end
            end else if (call) begin
                sel      = SEL_TGT;
                ras_push = 1'b1;
                set_ovf  = ras_full;
            end else if (jump || branch) begin
                sel = SEL_TGT;
            end
        end
    end

    always_comb begin
        case (sel)
            SEL_TGT: next_pc = target;
            SEL_POP: next_pc = ras_top;
            default: next_pc = seq_pc(addr_out);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_out      <= RESET_PC;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            if (advance) begin
                addr_out <= next_pc;
            end
            if (set_ovf) begin
                ras_overflow <= 1'b1;
            end
            if (set_unf) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    return_addr_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .din     (seq_pc(addr_out)),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: queue-based reference model compared every cycle plus literal checks.
module tb_pc_sequencer;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        branch;
    logic        jump;
    logic        call;
    logic        ret;
    logic [31:0] target;
    logic [31:0] addr_out;
    logic        addr_valid;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_chk  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch        (branch),
        .jump          (jump),
        .call          (call),
        .ret           (ret),
        .target        (target),
        .addr_out      (addr_out),
        .addr_valid    (addr_valid),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference model: PC value, LIFO of return addresses, sticky flags.
    logic [31:0] m_pc    = 32'd1;
    bit          m_valid = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;
    logic [31:0] m_ras[$];

    function automatic logic [31:0] m_seq(input logic [31:0] pc);
        return (pc == 32'd7) ? 32'd1 : pc + 32'd1;
    endfunction

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_pc    = 32'd1;
                m_valid = 1'b0;
                m_ovf   = 1'b0;
                m_unf   = 1'b0;
                m_ras.delete();
            end else if (!m_valid) begin
                m_valid = 1'b1;
            end else if (!stall) begin
                if (ret) begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc  = m_seq(m_pc);
                        m_unf = 1'b1;
                    end
                end else if (call) begin
                    if (m_ras.size() < 4) m_ras.push_back(m_seq(m_pc));
                    else m_ovf = 1'b1;
                    m_pc = target;
                end else if (jump || branch) begin
                    m_pc = target;
                end else begin
                    m_pc = m_seq(m_pc);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("model_addr", addr_out, m_pc);
            chk("model_valid", {31'b0, addr_valid}, {31'b0, m_valid});
            chk("model_ovf", {31'b0, ras_overflow}, {31'b0, m_ovf});
            chk("model_unf", {31'b0, ras_underflow}, {31'b0, m_unf});
        end
    end

    int seq_exp[8] = '{2, 3, 4, 5, 6, 7, 1, 2};
    int ret_exp[4] = '{31, 21, 11, 6};

    initial begin
        reset_n = 1'b0;
        stall   = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        call    = 1'b0;
        ret     = 1'b0;
        target  = '0;

        cyc(2);
        chk("rst_addr", addr_out, 32'd1);
        chk("rst_valid", {31'b0, addr_valid}, 32'd0);
        chk("rst_ovf", {31'b0, ras_overflow}, 32'd0);
        chk("rst_unf", {31'b0, ras_underflow}, 32'd0);
        reset_n = 1'b1;
        #1 chk("boot_valid", {31'b0, addr_valid}, 32'd0);
        cyc(1);
        chk("boot_done_valid", {31'b0, addr_valid}, 32'd1);
        chk("boot_done_addr", addr_out, 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            chk("seq_wrap", addr_out, 32'(seq_exp[i]));
        end

        jump = 1'b1; target = 32'd5;
        cyc(1); chk("jump", addr_out, 32'd5);
        jump = 1'b0;
        cyc(1); chk("jump_next", addr_out, 32'd6);
        cyc(3); chk("pre_branch", addr_out, 32'd2);
        branch = 1'b1; target = 32'd5;
        cyc(1); chk("branch", addr_out, 32'd5);
        branch = 1'b0;
        cyc(1); chk("branch_next", addr_out, 32'd6);
        cyc(3);
        jump = 1'b1; branch = 1'b1; target = 32'd5;
        cyc(1); chk("jump_branch", addr_out, 32'd5);
        jump = 1'b0; branch = 1'b0;

        cyc(5); chk("pre_call", addr_out, 32'd3);
        call = 1'b1; target = 32'd6;
        cyc(1); chk("call", addr_out, 32'd6);
        call = 1'b0; ret = 1'b1;
        cyc(1); chk("ret", addr_out, 32'd4);
        ret = 1'b0;
        call = 1'b1; target = 32'd2;
        cyc(1); chk("call2", addr_out, 32'd2);
        ret = 1'b1; target = 32'd7;
        cyc(1); chk("call_ret_pop_wins", addr_out, 32'd5);
        call = 1'b0; ret = 1'b0;

        cyc(6); chk("pre_stall", addr_out, 32'd4);
        stall = 1'b1; jump = 1'b1; target = 32'd2;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_hold", addr_out, 32'd4);
            chk("stall_valid", {31'b0, addr_valid}, 32'd1);
        end
        stall = 1'b0; jump = 1'b0;
        cyc(1); chk("stall_release", addr_out, 32'd5);

        for (int i = 0; i < 5; i++) begin
            call = 1'b1; target = 32'((i + 1) * 10);
            cyc(1);
            chk("nest_call", addr_out, 32'((i + 1) * 10));
            chk("nest_ovf", {31'b0, ras_overflow}, (i == 4) ? 32'd1 : 32'd0);
        end
        call = 1'b0; ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("nest_ret", addr_out, 32'(ret_exp[i]));
            chk("nest_unf", {31'b0, ras_underflow}, 32'd0);
        end
        cyc(1);
        chk("ret_empty_seq", addr_out, 32'd7);
        chk("ret_empty_unf", {31'b0, ras_underflow}, 32'd1);
        ret = 1'b0;

        call = 1'b1; target = 32'd6;
        cyc(1); chk("pre_reset", addr_out, 32'd6);
        call = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_addr", addr_out, 32'd1);
        chk("async_rst_ovf", {31'b0, ras_overflow}, 32'd0);
        chk("async_rst_unf", {31'b0, ras_underflow}, 32'd0);
        chk("async_rst_valid", {31'b0, addr_valid}, 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1); chk("reboot_addr", addr_out, 32'd1);
        ret = 1'b1;
        cyc(1);
        chk("ras_cleared_addr", addr_out, 32'd2);
        chk("ras_cleared_unf", {31'b0, ras_underflow}, 32'd1);
        ret = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the RISC CPU. It generalises address width, start and wrap addresses, and step size. It adds a stall input, a boot state, call/return through a small return-address stack (RAS), and sticky RAS error flags. It sits between the decode/branch unit, which supplies controls and target, and instruction memory, which consumes addr_out.

Parameters:
ADDR_W, 32, width of PC, target and addr_out
RESET_PC, 1, value loaded on reset and on wrap
WRAP_PC, 7, last sequential address; sequential step from WRAP_PC goes to RESET_PC
INCR, 1, sequential step size
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC; all controls ignored this cycle
branch  in  1  taken branch: load target
jump  in  1  jump: load target
call  in  1  load target, push return address
ret  in  1  pop RAS into PC
target  in  ADDR_W  branch/jump/call destination
addr_out  out  ADDR_W  current fetch address (registered)
addr_valid  out  1  addr_out is a valid fetch address
ras_overflow  out  1  sticky: call issued with RAS full
ras_underflow  out  1  sticky: ret issued with RAS empty

Behaviour:
- Reset (async assert, sync deassert by clock edge):
  - addr_out=RESET_PC, addr_valid=0, RAS empty, both flags=0, state=S_BOOT.
  - Reset mid-operation aborts immediately; RAS contents are discarded.
- FSM:
  - S_BOOT: lasts one cycle; controls and stall ignored; addr_out held; next state is S_RUN.
  - S_RUN: addr_valid=1; the FSM stays in S_RUN until reset.
- In S_RUN, each rising edge with stall=0 updates addr_out to next_pc. The priority order is ret > call > jump > branch > sequential.
  - ret with RAS non-empty: next_pc=top; pop.
  - ret with RAS empty: sequential step; ras_underflow<=1.
  - call: next_pc=target; push seq(addr_out).
    - If the RAS is full, the push is dropped (no overwrite), ras_overflow<=1, and the jump still occurs.
  - jump or branch: next_pc=target; no stack effect.
  - Sequential: seq(pc) = RESET_PC if pc==WRAP_PC, else pc+INCR, computed modulo 2^ADDR_W.
- Lower-priority controls asserted together with a higher-priority one are discarded (not queued).
- stall=1: addr_out, RAS and flags are unchanged; all controls are ignored. addr_valid stays 1.
- target is used verbatim. No range check is made, so a target above WRAP_PC is legal and counting continues from it. Sequential stepping wraps only on an exact match with WRAP_PC.
- Latency: a control sampled at edge N appears on addr_out after edge N, one cycle.
- Flags are sticky and are cleared only by reset_n.

Decomposition:
- Package pc_seq_pkg: state enum {S_BOOT, S_RUN}, and next-PC select encoding {SEL_SEQ, SEL_TGT, SEL_POP}.
- Sub-module return_addr_stack (params ADDR_W, RAS_DEPTH):
  - Inputs: push, pop, din.
  - Outputs: top, empty, full.
  - Pointer-based, with async active-low reset.
  - Push-when-full and pop-when-empty are no-ops.
- Priority/select logic and the FSM stay in the top level.

Test Plan:
- Defaults, reset released, no controls -> addr_valid 0 for one cycle at 1, then addr_out 1,2,3,4,5,6,7,1,2 on successive cycles.
- jump=1, target=5 while addr_out=2 -> next addr_out 5, then 6. Same stimulus with branch gives the same result. jump and branch together with target 5 -> 5.
- call with target=6 at addr_out=3 -> 6; then ret -> 4. call and ret in the same cycle with a non-empty RAS -> the pop wins and the call is ignored.
- stall held 3 cycles at addr_out=4 while jump=1 and target=2 -> addr_out stays 4. After stall drops, sequential resumes at 5; the jump is not queued.
- RAS_DEPTH=4: five nested calls -> ras_overflow=1 on the 5th. Five rets -> the first four return correct addresses in LIFO order, the fifth steps sequentially and sets ras_underflow=1.
- reset_n asserted mid-cycle at addr_out=6 with RAS non-empty -> addr_out=1 and flags 0 immediately, without waiting for an edge. A subsequent ret -> underflow, which proves the RAS was cleared.
